usb_in_packetizer: RTL and testbench
====================================

// Module: usb_in_packetizer
// PURPOSE
//  Downstream of the EP0 control/setup stage: drains the send queue and answers IN tokens.
//  Frames up to MAX_PKT bytes into a DATA0/DATA1 packet: PID byte, payload, CRC16 low byte, CRC16 high byte.
//  Holds the framed payload in a local buffer so a packet can be resent when no ACK arrives.
//  Feeds the byte-wide TX serializer. Replies NAK when it has no data and no ZLP is armed.
// PARAMETERS
//  MAX_PKT     8    EP0 max packet size in bytes (8..64)
//  PTR_W       6    buffer index width; 2**PTR_W >= MAX_PKT
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous, active-low reset
//  usb_rst        in   1  bus reset, synchronous, active-high; same effect as rst
//  in_token       in   1  1-cycle pulse: IN token for EP0 at our address
//  data_toggle    in   1  0=DATA0 (PID C3), 1=DATA1 (PID 4B); sampled when in_token fires
//  zlp_armed      in   1  send a zero-length DATAx when the queue is empty
//  q_empty        in   1  send queue empty
//  q_data         in   8  send queue read data, valid the cycle after q_r_en
//  q_r_en         out  1  send queue read strobe
//  tx_valid       out  1  tx_data valid
//  tx_data        out  8  packet byte to the serializer
//  tx_last        out  1  marks the final byte of a packet
//  tx_ready       in   1  serializer accepts the byte when tx_valid & tx_ready
//  hs_ack         in   1  1-cycle pulse: host ACK received
//  hs_timeout     in   1  1-cycle pulse: no handshake within the turnaround window
//  in_done        out  1  1-cycle pulse: a DATA packet was ACKed
//  busy           out  1  high in every state except IDLE/HOLD
// BEHAVIOUR
//  Reset (rst==0 or usb_rst==1): state IDLE, buffer count 0, all outputs 0. Aborts any packet in flight.
//  Loading:
//   - In IDLE with count<MAX_PKT and !q_empty: pulse q_r_en.
//   - Store q_data one cycle later; count+1.
//   - Maximum of one read outstanding at a time.
//  IDLE, on in_token:
//   - count>0 -> FRAME.
//   - count==0 & zlp_armed -> FRAME (ZLP).
//   - otherwise -> NAK.
//   - A read still outstanding completes before FRAME begins.
//  FRAME:
//   - Send sequence: PID, buf[0..count-1], crc[7:0], crc[15:8].
//   - tx_last is set on crc[15:8].
//   - Each byte is held until tx_ready; tx_valid never drops mid-packet.
//  CRC16 (USB):
//   - Poly 0x8005, reflected, init 0xFFFF, covers payload only; transmitted value is ~crc.
//   - ZLP CRC bytes are 00 00.
//   - Computed incrementally during transmit, 1 byte per accepted beat.
//  NAK: single byte 0x5A with tx_last=1, then IDLE.
//  After the last byte -> WAIT_HS:
//   - hs_ack: pulse in_done, count=0, -> IDLE.
//   - hs_timeout: keep the buffer and PID toggle -> HOLD.
//  HOLD:
//   - The next in_token resends the identical packet with the same PID.
//   - The queue is not read while in HOLD.
//  Simultaneous events:
//   - in_token while busy: ignored.
//   - hs_ack and hs_timeout in the same cycle: ack wins.
//  A count of exactly MAX_PKT stops loading. Any remaining bytes are left for the next transaction.
//  Latency: in_token to tx_valid is 1 cycle, or 2 if a read is outstanding.
// STRUCTURE
//  Shared package usb_pkg:
//   - PID constants: PID_DATA0=8'hC3, PID_DATA1=8'h4B, PID_NAK=8'h5A, PID_ACK=8'hD2.
//   - Constants CRC16_POLY and CRC16_INIT, state enum.
//  Sub-module usb_crc16: clr, en, din[7:0] -> crc[15:0]. It is reused by the RX side.
//  The buffer is a MAX_PKT x 8 register array; one FSM plus a byte index counter.
// TESTING
//  1 Queue preloaded with 12 34; data_toggle=0; in_token.
//    -> tx bytes C3 12 34 crcL crcH, tx_last on the 5th byte. CRC is checked against a bench reference model. Then hs_ack -> in_done.
//  2 Queue empty, zlp_armed=1, toggle=1, in_token -> 4B 00 00; queue empty, zlp_armed=0 -> single byte 5A, tx_last=1.
//  3 Queue holds 10 bytes, MAX_PKT=8.
//    -> First IN sends 8 bytes, ACK, and q_r_en then fetches the remaining 2.
//    -> Second IN (toggle=1) sends 4B plus 2 bytes.
//  4 hs_timeout after a packet -> HOLD; next in_token resends byte-identical packet, no q_r_en during HOLD.
//  5 tx_ready toggling randomly -> no byte lost or duplicated; in_token pulse mid-packet ignored.
//  6 usb_rst asserted mid-FRAME -> next cycle tx_valid=0, busy=0, count=0; following IN with empty queue yields NAK.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB device constants, FSM state type and a byte-wide CRC16 step
// used by both the IN packetizer and the RX checker.
package usb_pkg;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_ACK   = 8'hD2;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FRAME,
        S_NAK,
        S_WAIT_HS,
        S_HOLD
    } state_e;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // USB sends LSB first, so the register shifts right against the reflected poly.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ reflect16(CRC16_POLY);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Running USB CRC16 over a byte stream; crc is the raw register, the
// transmitted check value is its complement.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)     crc_d = CRC16_INIT;
        else if (en) crc_d = crc16_byte(crc_q, din);
    end

    always_ff @(posedge clk) begin
        if (!rst) crc_q <= CRC16_INIT;
        else      crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_in_packetizer.sv
// EP0 IN packetizer: buffers up to MAX_PKT queue bytes, frames them as a
// DATAx packet for the byte serializer, NAKs when idle, resends on timeout.
module usb_in_packetizer
    import usb_pkg::*;
#(
    parameter int MAX_PKT = 8,
    parameter int PTR_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_rst,
    input  logic       in_token,
    input  logic       data_toggle,
    input  logic       zlp_armed,
    input  logic       q_empty,
    input  logic [7:0] q_data,
    output logic       q_r_en,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_last,
    input  logic       tx_ready,
    input  logic       hs_ack,
    input  logic       hs_timeout,
    output logic       in_done,
    output logic       busy
);

    localparam int AW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam int CW = PTR_W + 1;
    localparam int IW = PTR_W + 2;

    logic          run;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_ld;
    logic [IW-1:0] idx_q, idx_d, last_idx;
    logic          rd_pend_q, rd_pend_d;
    logic [7:0]    pid_q, pid_d;
    logic [7:0]    mem_q [MAX_PKT];
    logic [7:0]    mem_d [MAX_PKT];
    logic [AW-1:0] pay_idx;
    logic          beat, crc_clr, crc_en;
    logic [15:0]   crc;

    assign run = rst & ~usb_rst;

    usb_crc16 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (tx_data),
        .crc (crc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pid_d     = pid_q;
        mem_d     = mem_q;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        in_done   = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        busy      = (state_q != S_IDLE) && (state_q != S_HOLD);
        pay_idx   = AW'(idx_q - IW'(1));
        last_idx  = IW'(cnt_q) + IW'(2);
        cnt_ld    = cnt_q + CW'(rd_pend_q);

        q_r_en    = (state_q == S_IDLE) && !rd_pend_q && !q_empty && (cnt_q < CW'(MAX_PKT));
        rd_pend_d = q_r_en;

        // Queue data lands one cycle after the strobe, whatever state we are in.
        if (rd_pend_q) begin
            mem_d[AW'(cnt_q)] = q_data;
            cnt_d             = cnt_ld;
        end

        beat = tx_valid & tx_ready;

        case (state_q)
            S_IDLE: begin
                if (in_token) begin
                    pid_d = data_toggle ? PID_DATA1 : PID_DATA0;
                    if (q_r_en) begin
                        state_d = S_LOAD;
                    end else if ((cnt_ld != '0) || zlp_armed) begin
                        state_d = S_FRAME;
                        idx_d   = '0;
                        crc_clr = 1'b1;
                    end else begin
                        state_d = S_NAK;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_FRAME;
                idx_d   = '0;
                crc_clr = 1'b1;
            end
            S_FRAME: begin
                tx_valid = 1'b1;
                tx_last  = (idx_q == last_idx);
                if (idx_q == '0)                 tx_data = pid_q;
                else if (idx_q <= IW'(cnt_q))    tx_data = mem_q[pay_idx];
                else if (idx_q != last_idx)      tx_data = ~crc[7:0];
                else                             tx_data = ~crc[15:8];
                beat = tx_ready;
                if (beat) begin
                    crc_en = (idx_q != '0) && (idx_q <= IW'(cnt_q));
                    idx_d  = idx_q + IW'(1);
                    if (tx_last) state_d = S_WAIT_HS;
                end
            end
            S_NAK: begin
                tx_valid = 1'b1;
                tx_data  = PID_NAK;
                tx_last  = 1'b1;
                if (tx_ready) state_d = S_IDLE;
            end
            S_WAIT_HS: begin
                if (hs_ack) begin
                    in_done = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (hs_timeout) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (in_token) begin
                    state_d = S_FRAME;
                    idx_d   = '0;
                    crc_clr = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!run) begin
            q_r_en   = 1'b0;
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            tx_last  = 1'b0;
            in_done  = 1'b0;
            busy     = 1'b0;
            crc_en   = 1'b0;
            crc_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            pid_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            pid_q     <= pid_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Directed bench for usb_in_packetizer: queue model, tx capture, and an
// MSB-first CRC16 reference built independently of the design's LSB-first loop.
module tb_usb_in_packetizer;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst, usb_rst, in_token, data_toggle, zlp_armed;
    logic       q_empty, q_r_en, tx_valid, tx_last, tx_ready;
    logic [7:0] q_data, tx_data;
    logic       hs_ack, hs_timeout, in_done, busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] qm [256];
    int         qrd = 0, qwr = 0;
    int         rdcnt = 0;
    bq_t        cap;
    logic       lst[$];

    always #5 clk = ~clk;

    usb_in_packetizer #(.MAX_PKT(8), .PTR_W(6)) dut (
        .clk(clk), .rst(rst), .usb_rst(usb_rst), .in_token(in_token),
        .data_toggle(data_toggle), .zlp_armed(zlp_armed), .q_empty(q_empty),
        .q_data(q_data), .q_r_en(q_r_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .hs_ack(hs_ack),
        .hs_timeout(hs_timeout), .in_done(in_done), .busy(busy)
    );

    assign q_empty = (qrd == qwr);

    always @(posedge clk) begin
        if (q_r_en) begin
            q_data <= qm[qrd[7:0]];
            qrd    <= qrd + 1;
            rdcnt  <= rdcnt + 1;
        end
        if (tx_valid && tx_ready) begin
            cap.push_back(tx_data);
            lst.push_back(tx_last);
        end
    end

    function automatic logic [15:0] ref_crc(input bq_t d);
        logic [15:0] c, r;
        logic [7:0]  rb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int j = 0; j < 8; j++) rb[j] = d[i][7-j];
            c = c ^ {rb, 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        for (int j = 0; j < 16; j++) r[j] = c[15-j];
        return ~r;
    endfunction

    function automatic bq_t mkpkt(input logic [7:0] pid, input bq_t pay);
        bq_t p;
        logic [15:0] c;
        c = ref_crc(pay);
        p.push_back(pid);
        foreach (pay[i]) p.push_back(pay[i]);
        p.push_back(c[7:0]);
        p.push_back(c[15:8]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        qm[qwr[7:0]] = b;
        qwr++;
    endtask

    task automatic token(input logic tog);
        data_toggle = tog;
        in_token    = 1'b1;
        @(negedge clk);
        in_token    = 1'b0;
    endtask

    task automatic wait_cap(input int n, input string tag);
        int t = 0;
        while (cap.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        cyc(2);
        chk(tag, cap.size(), n);
    endtask

    task automatic chk_pkt(input string tag, input bq_t exp);
        chk({tag, "_len"}, cap.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), cap[i], exp[i]);
            chk($sformatf("%s_last%0d", tag, i), lst[i], (i == exp.size() - 1));
        end
    endtask

    task automatic ack(input string tag);
        hs_ack = 1'b1;
        #1 chk({tag, "_in_done"}, in_done, 1'b1);
        @(negedge clk);
        hs_ack = 1'b0;
        chk({tag, "_busy_after_ack"}, busy, 1'b0);
    endtask

    task automatic clr_cap();
        cap.delete();
        lst.delete();
    endtask

    initial begin
        bq_t exp, first, pay;
        int  snap, drop;
        rst = 1'b0; usb_rst = 1'b0; in_token = 1'b0; data_toggle = 1'b0;
        zlp_armed = 1'b0; tx_ready = 1'b1; hs_ack = 1'b0; hs_timeout = 1'b0;

        // Test 1: two-byte DATA0 packet
        push(8'h12); push(8'h34);
        cyc(3);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_q_r_en", q_r_en, 1'b0);
        chk("rst_in_done", in_done, 1'b0);
        rst = 1'b1;
        cyc(8);
        chk("t1_reads", rdcnt, 2);
        data_toggle = 1'b0;
        in_token    = 1'b1;
        @(negedge clk);
        in_token    = 1'b0;
        chk("t1_latency", tx_valid, 1'b1);
        wait_cap(5, "t1_wait");
        pay = '{8'h12, 8'h34};
        chk_pkt("t1", mkpkt(8'hC3, pay));
        chk("t1_busy_wait_hs", busy, 1'b1);
        ack("t1");

        // Test 2: ZLP on DATA1, then NAK
        clr_cap();
        zlp_armed = 1'b1;
        token(1'b1);
        wait_cap(3, "t2z_wait");
        exp = '{8'h4B, 8'h00, 8'h00};
        chk_pkt("t2z", exp);
        ack("t2z");
        zlp_armed = 1'b0;
        clr_cap();
        token(1'b0);
        wait_cap(1, "t2n_wait");
        exp = '{8'h5A};
        chk_pkt("t2n", exp);
        chk("t2n_busy", busy, 1'b0);

        // Test 3: ten queued bytes, MAX_PKT 8
        clr_cap();
        rdcnt = 0;
        pay.delete();
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        cyc(30);
        chk("t3_reads_full", rdcnt, 8);
        chk("t3_left_in_q", qwr - qrd, 2);
        token(1'b0);
        wait_cap(11, "t3a_wait");
        for (int i = 0; i < 8; i++) pay.push_back(8'hA0 + 8'(i));
        chk_pkt("t3a", mkpkt(8'hC3, pay));
        ack("t3a");
        cyc(10);
        chk("t3_reads_rest", rdcnt, 10);
        clr_cap();
        token(1'b1);
        wait_cap(4 + 1, "t3b_wait");
        pay = '{8'hA8, 8'hA9};
        chk_pkt("t3b", mkpkt(8'h4B, pay));
        ack("t3b");

        // Test 4: timeout -> HOLD -> identical resend, no queue reads
        push(8'h55); push(8'hAA);
        cyc(8);
        clr_cap();
        token(1'b0);
        wait_cap(5, "t4a_wait");
        first = cap;
        pay = '{8'h55, 8'hAA};
        chk_pkt("t4a", mkpkt(8'hC3, pay));
        hs_timeout = 1'b1;
        @(negedge clk);
        hs_timeout = 1'b0;
        chk("t4_hold_busy", busy, 1'b0);
        snap = rdcnt;
        push(8'h77);
        cyc(10);
        chk("t4_no_read_in_hold", rdcnt, snap);
        clr_cap();
        token(1'b1);
        wait_cap(5, "t4b_wait");
        chk_pkt("t4b", first);
        ack("t4b");

        // Test 5: random back-pressure, stray in_token mid-packet
        for (int i = 1; i <= 5; i++) push(8'(i));
        cyc(20);
        clr_cap();
        token(1'b0);
        drop = 0;
        for (int t = 0; t < 400 && cap.size() < 9; t++) begin
            tx_ready = 1'($urandom_range(0, 1));
            in_token = (t == 4);
            #1;
            if (cap.size() < 9 && !tx_valid) drop++;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        in_token = 1'b0;
        cyc(2);
        chk("t5_no_drop", drop, 0);
        pay = '{8'h77, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_pkt("t5", mkpkt(8'hC3, pay));
        ack("t5");
        cyc(10);
        chk("t5_no_extra", cap.size(), 9);

        // Test 6: bus reset mid-frame
        push(8'h21); push(8'h22); push(8'h23);
        cyc(10);
        clr_cap();
        token(1'b0);
        cyc(2);
        usb_rst = 1'b1;
        @(negedge clk);
        chk("t6_tx_valid", tx_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        usb_rst = 1'b0;
        cyc(3);
        clr_cap();
        token(1'b0);
        wait_cap(1, "t6n_wait");
        exp = '{8'h5A};
        chk_pkt("t6n", exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
